// File: rtl/matrix_multiplier_pkg.sv
// Shared constants and types for the sequential 4x4 matrix by 4-vector
// multiplier.
//   ELEMS_PER_ROW / NUM_ROWS : matrix geometry
//   cnt_t                    : element and row counter type
//   state_t                  : control state (RUN accepts operands, DONE holds)
package matrix_multiplier_pkg;

  localparam int unsigned ELEMS_PER_ROW = 4;
  localparam int unsigned NUM_ROWS      = 4;
  localparam int unsigned CNT_W         = 2;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LAST_ELEM = cnt_t'(ELEMS_PER_ROW - 1);
  localparam cnt_t LAST_ROW  = cnt_t'(NUM_ROWS - 1);

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

endpackage

// File: rtl/matrix_multiplier_mac.sv
// mm_mac_unit: single unsigned multiply-accumulate stage.
//   clk, reset : clock and synchronous active-high reset (clears acc)
//   enable     : load acc with sum this cycle
//   clear      : zero acc this cycle (wins over enable)
//   a, b       : operands
//   product    : (a*b) mod 2^WIDTH
//   sum        : (acc + product) mod 2^WIDTH
//   acc        : current accumulator value
module mm_mac_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] acc
);

  assign product = a * b;
  assign sum     = acc + product;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/matrix_multiplier.sv
// matrix_multiplier: computes a 4x4 matrix times 4-vector product one operand
// pair per strobe, row-major, through a single MAC.
//   clk, reset                : clock and synchronous active-high reset
//   in1, in2                  : matrix element / vector element operands
//   inputs_to_multiply_ready  : operand strobe; a 0->1 transition accepts a pair
//   result0..result3          : dot product of matrix row 0..3 with the vector
//   done_matrixmult           : high once all four results are final
module matrix_multiplier
  import matrix_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             inputs_to_multiply_ready,
  output logic [WIDTH-1:0] result0,
  output logic [WIDTH-1:0] result1,
  output logic [WIDTH-1:0] result2,
  output logic [WIDTH-1:0] result3,
  output logic             done_matrixmult
);

  state_t           state, state_next;
  logic             ready_q;
  cnt_t             elem_cnt;
  cnt_t             row_cnt;
  logic             accept;
  logic             row_end;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] result_q [NUM_ROWS];

  // Rising-edge detect: a strobe held high is counted only once.
  assign accept  = inputs_to_multiply_ready && !ready_q && (state == RUN);
  assign row_end = accept && (elem_cnt == LAST_ELEM);

  mm_mac_unit #(.WIDTH(WIDTH)) u_mac (
    .clk     (clk),
    .reset   (reset),
    .enable  (accept),
    .clear   (row_end),
    .a       (in1),
    .b       (in2),
    .product (product),
    .sum     (sum),
    .acc     (acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (row_end && (row_cnt == LAST_ROW)) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q  <= 1'b0;
      elem_cnt <= '0;
      row_cnt  <= '0;
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        result_q[i] <= '0;
      end
    end else begin
      ready_q <= inputs_to_multiply_ready;
      if (row_end) begin
        result_q[row_cnt] <= sum;
        elem_cnt          <= '0;
        if (row_cnt != LAST_ROW) begin
          row_cnt <= row_cnt + 1'b1;
        end
      end else if (accept) begin
        elem_cnt <= elem_cnt + 1'b1;
      end
    end
  end

  assign result0         = result_q[0];
  assign result1         = result_q[1];
  assign result2         = result_q[2];
  assign result3         = result_q[3];
  assign done_matrixmult = (state == DONE);

endmodule

// File: tb/tb_matrix_multiplier.sv
// Self-checking bench for matrix_multiplier: directed vectors plus randomized
// matrices checked against a plain-arithmetic dot-product model.
module tb_matrix_multiplier;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] in1, in2;
  logic             rdy;
  logic [WIDTH-1:0] result0, result1, result2, result3;
  logic             done_matrixmult;

  int tests_run = 0;
  int tests_failed = 0;

  logic [WIDTH-1:0] mat [16];
  logic [WIDTH-1:0] vec [4];
  logic [WIDTH-1:0] exp_res [4];

  always #5 clk = ~clk;

  matrix_multiplier #(.WIDTH(WIDTH)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .in1                      (in1),
    .in2                      (in2),
    .inputs_to_multiply_ready (rdy),
    .result0                  (result0),
    .result1                  (result1),
    .result2                  (result2),
    .result3                  (result3),
    .done_matrixmult          (done_matrixmult)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
    end
  endtask

  // Expected outputs given that rows 0..rows_done-1 are complete.
  task automatic check_outputs(input string tag, input int rows_done);
    logic [WIDTH-1:0] e [4];
    for (int r = 0; r < 4; r++) e[r] = (r < rows_done) ? exp_res[r] : '0;
    check({tag, ".r0"}, result0, e[0]);
    check({tag, ".r1"}, result1, e[1]);
    check({tag, ".r2"}, result2, e[2]);
    check({tag, ".r3"}, result3, e[3]);
    check({tag, ".done"}, {31'b0, done_matrixmult}, (rows_done == 4) ? 1 : 0);
  endtask

  task automatic compute_model();
    for (int r = 0; r < 4; r++) begin
      exp_res[r] = '0;
      for (int c = 0; c < 4; c++) exp_res[r] += mat[r*4+c] * vec[c];
    end
  endtask

  // One-cycle strobe followed by a low cycle; inputs change on negedge.
  task automatic strobe(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    in1 = a; in2 = b; rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rdy = 1'b1;   // rising strobe during reset must be ignored
    in1 = 32'd7; in2 = 32'd9;
    @(negedge clk);
    rdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Feed the whole matrix, checking the outputs after each row.
  task automatic run_matrix(input string tag);
    compute_model();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) strobe(mat[r*4+c], vec[c]);
      @(negedge clk);
      check_outputs($sformatf("%s.row%0d", tag, r), r + 1);
    end
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b0; in1 = '0; in2 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("reset", 0);

    // Directed full run.
    mat = '{1,1,2,3, 5,6,7,3, 1,2,3,2, 4,5,3,5};
    vec = '{2,5,3,1};
    compute_model();
    check("model.r0", exp_res[0], 32'd16);
    check("model.r3", exp_res[3], 32'd47);
    run_matrix("full");

    // Held strobe after done and fresh strobes: nothing changes.
    @(negedge clk);
    in1 = 32'd100; in2 = 32'd100; rdy = 1'b1;
    repeat (6) @(negedge clk);
    check_outputs("post_done_held", 4);
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) strobe(32'd11 + i, 32'd3);
    @(negedge clk);
    check_outputs("post_done_strobe", 4);

    // Held strobe counts once: 3*4 then 1*1 x3 -> 15.
    do_reset();
    check_outputs("reset2", 0);
    @(negedge clk);
    in1 = 32'd3; in2 = 32'd4; rdy = 1'b1;
    repeat (5) @(negedge clk);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) strobe(32'd1, 32'd1);
    @(negedge clk);
    check("held.r0", result0, 32'd15);
    check("held.r1", result1, 32'd0);

    // Wrap: each product 2^32 -> 0.
    do_reset();
    for (int i = 0; i < 4; i++) strobe(32'h0001_0000, 32'h0001_0000);
    @(negedge clk);
    check("wrap.r0", result0, 32'd0);
    for (int i = 0; i < 4; i++) strobe(32'hFFFF_FFFF, 32'd2);
    @(negedge clk);
    check("wrap.r1", result1, 32'hFFFF_FFF8);

    // Reset mid-row 1, then a full run must be unaffected.
    do_reset();
    mat = '{1,1,2,3, 5,6,7,3, 1,2,3,2, 4,5,3,5};
    vec = '{2,5,3,1};
    compute_model();
    for (int c = 0; c < 4; c++) strobe(mat[c], vec[c]);
    strobe(32'd5, 32'd2);
    strobe(32'd6, 32'd5);
    do_reset();
    @(negedge clk);
    check_outputs("mid_reset", 0);
    run_matrix("rerun");

    // Randomized matrices.
    for (int t = 0; t < 12; t++) begin
      do_reset();
      for (int i = 0; i < 16; i++) mat[i] = (t < 6) ? $urandom_range(0, 255) : $urandom;
      for (int i = 0; i < 4; i++)  vec[i] = (t < 6) ? $urandom_range(0, 255) : $urandom;
      run_matrix($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
